parity_frame_checker: RTL and testbench

Parametrised serial parity checker for the bit-serial receive path. It collects a framed word of DATA_BITS data bits followed by one parity bit. It checks the frame against even or odd parity, selected per frame, and presents the deserialised word. It also keeps a saturating error counter. It is the generalised successor of the single-bit even-parity FSM: it adds framing, bit-valid handshake, mode select, deserialisation and error statistics.

---
 rtl/parity_frame_checker.sv | 131 +++++++++++++
 tb/tb_parity_frame_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_checker.sv
// Serial parity frame checker: deserialises DATA_BITS data bits plus one parity bit,
// checks even/odd parity chosen per frame, and keeps a saturating error count.
module parity_frame_checker #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CNT_W     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 bit_valid,
    input  logic                 input_bit,
    input  logic                 odd_mode,
    input  logic                 clear_cnt,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_done,
    output logic                 parity_error,
    output logic [CNT_W-1:0]     err_count,
    output logic                 busy,
    output logic                 running_parity
);

    localparam int unsigned CNT_BITS = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  acc_q, acc_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  done_q, done_d;
    logic                  perr_q, perr_d;
    logic [CNT_W-1:0]      errcnt_q, errcnt_d;
    logic [CNT_BITS-1:0]   pos;
    logic                  err;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            acc_q    <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            perr_q   <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            acc_q    <= acc_d;
            data_q   <= data_d;
            done_q   <= done_d;
            perr_q   <= perr_d;
            errcnt_q <= errcnt_d;
        end
    end

    // Next-state and next-output logic; start overrides everything, including a coincident bit
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        acc_d    = acc_q;
        data_d   = data_q;
        done_d   = 1'b0;
        perr_d   = perr_q;
        errcnt_d = errcnt_q;
        err      = 1'b0;
        pos      = LSB_FIRST ? cnt_q : (LAST_IDX - cnt_q);

        if (start) begin
            state_d = S_DATA;
            cnt_d   = '0;
            acc_d   = odd_mode;
            shreg_d = '0;
        end else begin
            case (state_q)
                S_DATA: begin
                    if (bit_valid) begin
                        for (int unsigned i = 0; i < DATA_BITS; i++) begin
                            if (pos == CNT_BITS'(i)) begin
                                shreg_d[i] = input_bit;
                            end
                        end
                        acc_d = acc_q ^ input_bit;
                        if (cnt_q == LAST_IDX) begin
                            state_d = S_PARITY;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_BITS'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_valid) begin
                        err     = acc_q ^ input_bit;
                        data_d  = shreg_q;
                        perr_d  = err;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                        if (err && (errcnt_q != {CNT_W{1'b1}})) begin
                            errcnt_d = errcnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        if (clear_cnt) begin
            errcnt_d = '0;
        end
    end

    assign data_out       = data_q;
    assign frame_done     = done_q;
    assign parity_error   = perr_q;
    assign err_count      = errcnt_q;
    assign busy           = (state_q != S_IDLE);
    assign running_parity = acc_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker (DATA_BITS=8, CNT_W=2, LSB_FIRST=1).
module tb_parity_frame_checker;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          bit_valid;
    logic          input_bit;
    logic          odd_mode;
    logic          clear_cnt;
    logic [DW-1:0] data_out;
    logic          frame_done;
    logic          parity_error;
    logic [CW-1:0] err_count;
    logic          busy;
    logic          running_parity;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int done_before;

    parity_frame_checker #(.DATA_BITS(DW), .CNT_W(CW), .LSB_FIRST(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .bit_valid      (bit_valid),
        .input_bit      (input_bit),
        .odd_mode       (odd_mode),
        .clear_cnt      (clear_cnt),
        .data_out       (data_out),
        .frame_done     (frame_done),
        .parity_error   (parity_error),
        .err_count      (err_count),
        .busy           (busy),
        .running_parity (running_parity)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a frame, send data LSB first (optional idle gaps), then the parity bit
    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic odd,
                              input bit gaps, input logic sbv, input logic clr);
        start = 1'b1; odd_mode = odd; bit_valid = sbv; input_bit = sbv;
        tick();
        start = 1'b0; bit_valid = 1'b0;
        odd_mode = ~odd;
        check("busy_after_start", 32'(busy), 32'd1);
        check("seed_parity", 32'(running_parity), 32'(odd));
        for (int i = 0; i < int'(DW); i++) begin
            if (gaps) repeat (i % 4) tick();
            bit_valid = 1'b1; input_bit = d[i];
            tick();
            bit_valid = 1'b0;
        end
        if (gaps) repeat (2) tick();
        bit_valid = 1'b1; input_bit = p; clear_cnt = clr;
        tick();
        bit_valid = 1'b0; clear_cnt = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; bit_valid = 1'b0; input_bit = 1'b0;
        odd_mode = 1'b0; clear_cnt = 1'b0;
        #12;
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_perr", 32'(parity_error), 32'd0);
        check("rst_cnt", 32'(err_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rp", 32'(running_parity), 32'd0);
        reset = 1'b1;
        tick();

        // 1: good even frame 0xA5
        done_before = done_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s1_done", 32'(frame_done), 32'd1);
        check("s1_data", 32'(data_out), 32'hA5);
        check("s1_perr", 32'(parity_error), 32'd0);
        check("s1_cnt", 32'(err_count), 32'd0);
        check("s1_busy", 32'(busy), 32'd0);
        tick();
        check("s1_done_pulse", 32'(frame_done), 32'd0);
        check("s1_done_count", 32'(done_cnt - done_before), 32'd1);

        // 2: bad parity, then good odd frame 0x07
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s2_perr", 32'(parity_error), 32'd1);
        check("s2_cnt", 32'(err_count), 32'd1);
        send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("s2_odd_done", 32'(frame_done), 32'd1);
        check("s2_odd_data", 32'(data_out), 32'h07);
        check("s2_odd_perr", 32'(parity_error), 32'd0);
        check("s2_odd_cnt", 32'(err_count), 32'd1);

        // 3: gaps and bit_valid in the start cycle
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("s3_done", 32'(frame_done), 32'd1);
        check("s3_data", 32'(data_out), 32'hA5);
        check("s3_perr", 32'(parity_error), 32'd0);

        // 4: abort after 4 bits, then full 0x3C frame
        tick();
        done_before = done_cnt;
        start = 1'b1; odd_mode = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; input_bit = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        check("s4_abort_hold", 32'(data_out), 32'hA5);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s4_data", 32'(data_out), 32'h3C);
        check("s4_perr", 32'(parity_error), 32'd0);
        tick();
        check("s4_one_done", 32'(done_cnt - done_before), 32'd1);

        // 4b: start coincident with the parity bit aborts; the bit is discarded
        done_before = done_cnt;
        start = 1'b1; odd_mode = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < int'(DW); i++) begin
            bit_valid = 1'b1; input_bit = 1'b0;
            tick();
        end
        start = 1'b1; odd_mode = 1'b1; bit_valid = 1'b1; input_bit = 1'b1;
        tick();
        start = 1'b0; bit_valid = 1'b0;
        check("s4b_no_done", 32'(frame_done), 32'd0);
        check("s4b_busy", 32'(busy), 32'd1);
        check("s4b_seed", 32'(running_parity), 32'd1);
        check("s4b_data_hold", 32'(data_out), 32'h3C);
        check("s4b_cnt_hold", 32'(err_count), 32'd1);
        check("s4b_done_count", 32'(done_cnt - done_before), 32'd0);

        // 5: clear, saturation, clear beats increment
        clear_cnt = 1'b1;
        tick();
        clear_cnt = 1'b0;
        check("s5_cleared", 32'(err_count), 32'd0);
        for (int k = 0; k < 5; k++) begin
            send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check("s5_sat", 32'(err_count), (k < 3) ? 32'(k + 1) : 32'd3);
        end
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("s5_clr_win", 32'(err_count), 32'd0);
        check("s5_clr_perr", 32'(parity_error), 32'd1);

        // 6: async reset mid-DATA, then a clean frame
        start = 1'b1; odd_mode = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1; input_bit = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("s6_busy", 32'(busy), 32'd0);
        check("s6_data", 32'(data_out), 32'h0);
        check("s6_perr", 32'(parity_error), 32'd0);
        check("s6_rp", 32'(running_parity), 32'd0);
        #1 reset = 1'b1;
        done_before = done_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s6_done", 32'(frame_done), 32'd1);
        check("s6_data_after", 32'(data_out), 32'hA5);
        check("s6_perr_after", 32'(parity_error), 32'd0);
        check("s6_cnt_after", 32'(err_count), 32'd0);
        tick();
        check("s6_done_count", 32'(done_cnt - done_before), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
